// File: rtl/idex_stage_reg_if.sv
// ID/EX stage bundle: decoded operands/control from ID, registered fields to EX
// and forwarding, plus the load-use stall back to IF/ID.
interface idex_stage_reg_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16
);
  // Pipeline control
  logic            hold;
  logic            flush;

  // Hazard-detection view of the instruction in ID
  logic [4:0]      IFID_rs_in;
  logic [4:0]      IFID_rt_in;
  logic            IFID_rt_used;

  // Decoded ID-stage fields
  logic [DW-1:0]   ID_pc4_in;
  logic [DW-1:0]   ID_dataA_in;
  logic [DW-1:0]   ID_dataB_in;
  logic [DW-1:0]   ID_imm_in;
  logic [4:0]      ID_rd_in;
  logic [4:0]      ID_shamt_in;
  logic [15:0]     ID_ctrl_in;
  logic            ID_valid_in;

  // Registered EX-stage fields
  logic [DW-1:0]   IDEX_pc4_out;
  logic [DW-1:0]   IDEX_dataA_out;
  logic [DW-1:0]   IDEX_dataB_out;
  logic [DW-1:0]   IDEX_imm_out;
  logic [4:0]      IDEX_rs_out;
  logic [4:0]      IDEX_rt_out;
  logic [4:0]      IDEX_rd_out;
  logic [4:0]      IDEX_shamt_out;
  logic [15:0]     IDEX_ctrl_out;
  logic            IDEX_valid_out;

  // Hazard outputs
  logic            stall_out;
  logic [CNTW-1:0] bubble_cnt;

  // Upstream pipeline side (ID stage / hazard unit consumer)
  modport master (
    output hold, flush,
    output IFID_rs_in, IFID_rt_in, IFID_rt_used,
    output ID_pc4_in, ID_dataA_in, ID_dataB_in, ID_imm_in,
    output ID_rd_in, ID_shamt_in, ID_ctrl_in, ID_valid_in,
    input  IDEX_pc4_out, IDEX_dataA_out, IDEX_dataB_out, IDEX_imm_out,
    input  IDEX_rs_out, IDEX_rt_out, IDEX_rd_out, IDEX_shamt_out,
    input  IDEX_ctrl_out, IDEX_valid_out,
    input  stall_out, bubble_cnt
  );

  // The ID/EX register itself
  modport slave (
    input  hold, flush,
    input  IFID_rs_in, IFID_rt_in, IFID_rt_used,
    input  ID_pc4_in, ID_dataA_in, ID_dataB_in, ID_imm_in,
    input  ID_rd_in, ID_shamt_in, ID_ctrl_in, ID_valid_in,
    output IDEX_pc4_out, IDEX_dataA_out, IDEX_dataB_out, IDEX_imm_out,
    output IDEX_rs_out, IDEX_rt_out, IDEX_rd_out, IDEX_shamt_out,
    output IDEX_ctrl_out, IDEX_valid_out,
    output stall_out, bubble_cnt
  );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Priority each edge: hold > flush (incl. one deferred across a hold) > load-use
// bubble > normal capture. DW/CNTW must match the connected interface.
module idex_stage_reg #(
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16
) (
  input logic            clk,
  input logic            reset,
  idex_stage_reg_if.slave bus
);

  // Control-word bit positions used locally
  localparam int unsigned CtrlMemRead = 1;

  // Registered state
  logic [DW-1:0]   pc4_q,    pc4_d;
  logic [DW-1:0]   data_a_q, data_a_d;
  logic [DW-1:0]   data_b_q, data_b_d;
  logic [DW-1:0]   imm_q,    imm_d;
  logic [4:0]      rs_q,     rs_d;
  logic [4:0]      rt_q,     rt_d;
  logic [4:0]      rd_q,     rd_d;
  logic [4:0]      shamt_q,  shamt_d;
  logic [15:0]     ctrl_q,   ctrl_d;
  logic            valid_q,  valid_d;
  logic [CNTW-1:0] cnt_q,    cnt_d;
  // A flush that arrived during a hold must still kill the instruction once
  // the pipeline moves again.
  logic            flush_pend_q, flush_pend_d;

  logic            haz;
  logic            flush_eff;
  logic            rs_match;
  logic            rt_match;

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    rs_match  = (rt_q == bus.IFID_rs_in);
    rt_match  = bus.IFID_rt_used & (rt_q == bus.IFID_rt_in);
    haz       = valid_q & ctrl_q[CtrlMemRead] & (rt_q != 5'd0) & (rs_match | rt_match);
    flush_eff = bus.flush | flush_pend_q;
  end

  // Next-state selection in priority order
  always_comb begin
    pc4_d        = pc4_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    shamt_d      = shamt_q;
    ctrl_d       = ctrl_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;

    if (bus.hold) begin
      flush_pend_d = flush_pend_q | bus.flush;
    end else if (flush_eff || haz) begin
      // Bubble: zero register ids keep the forwarding compares from matching
      pc4_d        = '0;
      data_a_d     = '0;
      data_b_d     = '0;
      imm_d        = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      shamt_d      = '0;
      ctrl_d       = '0;
      valid_d      = 1'b0;
      flush_pend_d = 1'b0;
      // Only load-use bubbles are counted; a flush overrides the hazard
      if (!flush_eff && (cnt_q != {CNTW{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      pc4_d    = bus.ID_pc4_in;
      data_a_d = bus.ID_dataA_in;
      data_b_d = bus.ID_dataB_in;
      imm_d    = bus.ID_imm_in;
      rs_d     = bus.IFID_rs_in;
      rt_d     = bus.IFID_rt_in;
      rd_d     = bus.ID_rd_in;
      shamt_d  = bus.ID_shamt_in;
      ctrl_d   = bus.ID_ctrl_in;
      valid_d  = bus.ID_valid_in;
    end
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc4_q        <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      shamt_q      <= '0;
      ctrl_q       <= '0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      pc4_q        <= pc4_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      shamt_q      <= shamt_d;
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Output drive; stall is suppressed by flushes, holds and reset
  always_comb begin
    bus.IDEX_pc4_out   = pc4_q;
    bus.IDEX_dataA_out = data_a_q;
    bus.IDEX_dataB_out = data_b_q;
    bus.IDEX_imm_out   = imm_q;
    bus.IDEX_rs_out    = rs_q;
    bus.IDEX_rt_out    = rt_q;
    bus.IDEX_rd_out    = rd_q;
    bus.IDEX_shamt_out = shamt_q;
    bus.IDEX_ctrl_out  = ctrl_q;
    bus.IDEX_valid_out = valid_q;
    bus.bubble_cnt     = cnt_q;
    bus.stall_out      = haz & ~flush_eff & ~bus.hold & ~reset;
  end

endmodule

// File: doc/idex_stage_reg.md
Name: idex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and bubble insertion.
- Captures decoded operands and control from the ID stage.
- Drives the EX stage, and drives the rs/rt/RegWr/MemRead fields that the forwarding logic compares against EX/MEM and MEM/WB.
- Generates the stall that freezes PC and IF/ID. Also honours branch/jump flushes and a global pipeline hold.

Parameters:
- DW, 32, datapath width of PC+4, operand and immediate fields.
- CNTW, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  global freeze (memory wait); all state holds.
- flush  in  1  branch/jump taken, resolved in EX; kill the instruction entering EX.
- IFID_rs_in  in  5  rs of the instruction in ID.
- IFID_rt_in  in  5  rt of the instruction in ID.
- IFID_rt_used  in  1  instruction in ID reads rt as a source.
- ID_pc4_in  in  DW  PC+4 from ID.
- ID_dataA_in  in  DW  register-file rs data.
- ID_dataB_in  in  DW  register-file rt data.
- ID_imm_in  in  DW  extended immediate.
- ID_rd_in  in  5  rd field.
- ID_shamt_in  in  5  shift amount.
- ID_ctrl_in  in  16  packed control: [0]RegWr [1]MemRead [2]MemWr [4:3]MemtoReg [6:5]RegDst [7]ALUSrcA [8]ALUSrcB [13:9]ALUCtrl [15:14]reserved.
- ID_valid_in  in  1  ID holds a real instruction.
- IDEX_pc4_out  out  DW  registered PC+4.
- IDEX_dataA_out  out  DW  registered rs data.
- IDEX_dataB_out  out  DW  registered rt data.
- IDEX_imm_out  out  DW  registered immediate.
- IDEX_rs_out  out  5  registered rs (to forwarding).
- IDEX_rt_out  out  5  registered rt (to forwarding).
- IDEX_rd_out  out  5  registered rd.
- IDEX_shamt_out  out  5  registered shamt.
- IDEX_ctrl_out  out  16  registered control.
- IDEX_valid_out  out  1  EX holds a real instruction.
- stall_out  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_cnt  out  CNTW  count of bubbles inserted.

Behaviour:
- Reset (async, immediate): all outputs except stall_out = 0. flush_pend = 0. stall_out = 0 while reset is high.
- Hazard condition, combinational:
  - haz = IDEX_valid_out & IDEX_ctrl_out[1] & (IDEX_rt_out != 0) & ((IDEX_rt_out == IFID_rs_in) | (IFID_rt_used & IDEX_rt_out == IFID_rt_in)).
- stall_out = haz & ~flush_eff & ~hold.
  - flush_eff = flush | flush_pend.
- Register update on each rising clk, priority order:
  1. hold=1: every register keeps its value. If flush=1, set flush_pend=1.
  2. flush_eff=1: load a bubble and clear flush_pend.
  3. haz=1: load a bubble and increment bubble_cnt.
  4. Otherwise: load all ID_* inputs and ID_valid_in.
- Bubble contents:
  - ctrl = 0 and valid = 0.
  - rs/rt/rd = 0, so the forwarding compares never match.
  - Data fields = 0.
  - A bubble never writes a register or memory.
- Latency: one cycle ID to EX.
  - A load-use pair gives exactly one bubble: next cycle the load is in EX/MEM, IDEX_valid_out=0, and haz deasserts.
- bubble_cnt saturates at all-ones. It is not incremented on flush bubbles or while hold=1.
- Simultaneous flush and haz: flush wins. No stall, no count; the instruction in ID is killed upstream.
- Reset mid-hold, or with flush_pend set: everything clears, and the pending flush is discarded.
- IDEX_rt_out == 0 never stalls (r0 destination).

Test Plan:
- Load-use hazard: EX holds lw with ctrl[1]=1, rt=5, valid=1; ID holds add with rs=5. stall_out=1 that cycle. Next edge: IDEX_ctrl_out=0, valid=0, bubble_cnt=1. Following edge: add enters, stall_out=0.
- rt-use gating: load rt=5, ID rt=5, IFID_rt_used=0 -> stall_out=0 and the instruction passes. Same stimulus with IFID_rt_used=1 -> stall_out=1.
- Flush with hazard: flush=1 while haz conditions hold -> stall_out=0. Next edge: bubble loaded, bubble_cnt unchanged.
- Flush during hold: hold=1 and flush=1 for 3 cycles, then hold=0 with flush=0. Outputs frozen during the hold, flush_pend=1. First free edge loads a bubble and clears flush_pend.
- Counter saturation: CNTW=4, 17 load-use bubbles -> bubble_cnt=4'hF and stays there.
- Async reset: assert reset mid-cycle with valid data held -> all outputs 0 immediately, before any clock edge. Release -> normal loading on the next edge.
